// File: rtl/bpu_tournament.sv
// Tournament branch predictor: bimodal + gshare + chooser, direct-mapped BTB, speculative GHR.
// Optional return-address stack enabled by defining BPU_RAS_EN.
module bpu_tournament #(
  parameter int XLEN      = 32,
  parameter int HISLEN    = 8,
  parameter int BHT_IDX   = 8,
  parameter int BTB_IDX   = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid_i,
  input  logic              fetch_stall_i,
  input  logic [XLEN-1:0]   fetch_pc_i,
  output logic              pdt_res_o,
  output logic [XLEN-1:0]   pdt_target_o,
  output logic [XLEN-1:0]   pdt_tag_o,
  output logic              which_pdt_o,
  output logic [HISLEN-1:0] history_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_correct_i,
  input  logic              upd_which_pdt_i,
  input  logic [HISLEN-1:0] upd_history_i,
  input  logic [1:0]        upd_jump_type_i,
  input  logic [4:0]        upd_rd_i
);

  localparam int TAG_W = XLEN - BTB_IDX - 2;
  localparam int BHT_N = 1 << BHT_IDX;
  localparam int GSH_N = 1 << HISLEN;
  localparam int BTB_N = 1 << BTB_IDX;

  typedef enum logic [1:0] {
    JT_NONE   = 2'b00,
    JT_JAL    = 2'b01,
    JT_JALR   = 2'b10,
    JT_BRANCH = 2'b11
  } jump_type_e;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  logic [1:0]        bim_reg        [BHT_N];
  logic [1:0]        cho_reg        [BHT_N];
  logic [1:0]        gsh_reg        [GSH_N];
  logic              btb_valid_reg  [BTB_N];
  logic [TAG_W-1:0]  btb_tag_reg    [BTB_N];
  logic [XLEN-1:0]   btb_target_reg [BTB_N];
  jump_type_e        btb_type_reg   [BTB_N];
  logic [HISLEN-1:0] ghr_reg;
  logic [HISLEN-1:0] ghr_next;

  // ---------------- prediction path (reads pre-update table state) ----------------
  logic [BHT_IDX-1:0] f_bht_idx;
  logic [HISLEN-1:0]  f_gsh_idx;
  logic [BTB_IDX-1:0] f_btb_idx;
  logic               f_hit;
  logic               f_is_branch;
  logic               f_is_jump;
  logic               use_gshare;
  logic [1:0]         sel_ctr;
  logic               pred_taken;
  logic [XLEN-1:0]    jump_target;
  logic [XLEN-1:0]    pred_target;
  logic               fetch_go;
  logic [XLEN-1:0]    fetch_pc_plus4;

  assign fetch_go       = fetch_valid_i & ~fetch_stall_i;
  assign fetch_pc_plus4 = fetch_pc_i + XLEN'(4);
  assign f_bht_idx      = fetch_pc_i[BHT_IDX+1:2];
  assign f_gsh_idx      = fetch_pc_i[HISLEN+1:2] ^ ghr_reg;
  assign f_btb_idx      = fetch_pc_i[BTB_IDX+1:2];
  assign f_hit          = btb_valid_reg[f_btb_idx] &&
                          (btb_tag_reg[f_btb_idx] == fetch_pc_i[XLEN-1:BTB_IDX+2]);
  assign f_is_branch    = f_hit && (btb_type_reg[f_btb_idx] == JT_BRANCH);
  assign f_is_jump      = f_hit && ((btb_type_reg[f_btb_idx] == JT_JAL) ||
                                    (btb_type_reg[f_btb_idx] == JT_JALR));
  assign use_gshare     = cho_reg[f_bht_idx][1];
  assign sel_ctr        = use_gshare ? gsh_reg[f_gsh_idx] : bim_reg[f_bht_idx];
  assign pred_taken     = f_is_jump | (f_is_branch & sel_ctr[1]);
  assign pred_target    = pred_taken ? jump_target : fetch_pc_plus4;

  // ---------------- update path ----------------
  logic               upd_go;
  logic               upd_branch;
  logic [BHT_IDX-1:0] u_bht_idx;
  logic [HISLEN-1:0]  u_gsh_idx;
  logic [BTB_IDX-1:0] u_btb_idx;
  logic [1:0]         u_bim;
  logic [1:0]         u_gsh;
  logic [1:0]         bim_next;
  logic [1:0]         gsh_next;
  logic [1:0]         cho_next;
  logic               btb_write;

  assign upd_go     = upd_valid_i && (upd_jump_type_i != JT_NONE);
  assign upd_branch = upd_valid_i && (upd_jump_type_i == JT_BRANCH);
  assign u_bht_idx  = upd_pc_i[BHT_IDX+1:2];
  assign u_gsh_idx  = upd_pc_i[HISLEN+1:2] ^ upd_history_i;
  assign u_btb_idx  = upd_pc_i[BTB_IDX+1:2];
  assign u_bim      = bim_reg[u_bht_idx];
  assign u_gsh      = gsh_reg[u_gsh_idx];
  assign bim_next   = sat_step(u_bim, upd_taken_i);
  assign gsh_next   = sat_step(u_gsh, upd_taken_i);
  assign btb_write  = upd_go && upd_taken_i;

  // Chooser only learns when the two component predictors disagreed.
  always_comb begin
    cho_next = cho_reg[u_bht_idx];
    if (u_bim[1] != u_gsh[1]) begin
      cho_next = sat_step(cho_reg[u_bht_idx], u_gsh[1] == upd_taken_i);
    end
  end

  // A mispredict restore overrides both the speculative shift and a stall hold.
  always_comb begin
    ghr_next = ghr_reg;
    if (fetch_go && f_is_branch) begin
      ghr_next = {ghr_reg[HISLEN-2:0], pred_taken};
    end
    if (upd_go && !upd_correct_i) begin
      ghr_next = (upd_jump_type_i == JT_BRANCH) ?
                 {upd_history_i[HISLEN-2:0], upd_taken_i} : upd_history_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_reg <= '0;
    else     ghr_reg <= ghr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pdt_res_o    <= 1'b0;
      pdt_target_o <= '0;
      pdt_tag_o    <= '0;
      which_pdt_o  <= 1'b0;
      history_o    <= '0;
    end else if (fetch_go) begin
      pdt_res_o    <= pred_taken;
      pdt_target_o <= pred_target;
      pdt_tag_o    <= fetch_pc_i;
      which_pdt_o  <= use_gshare;
      history_o    <= ghr_reg;
    end else if (!fetch_stall_i) begin
      pdt_res_o    <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_N; gi++) begin : g_bht
      always_ff @(posedge clk) begin
        if (rst) begin
          bim_reg[gi] <= 2'b01;
          cho_reg[gi] <= 2'b01;
        end else if (upd_branch && (u_bht_idx == BHT_IDX'(gi))) begin
          bim_reg[gi] <= bim_next;
          cho_reg[gi] <= cho_next;
        end
      end
    end

    for (gi = 0; gi < GSH_N; gi++) begin : g_gsh
      always_ff @(posedge clk) begin
        if (rst) begin
          gsh_reg[gi] <= 2'b01;
        end else if (upd_branch && (u_gsh_idx == HISLEN'(gi))) begin
          gsh_reg[gi] <= gsh_next;
        end
      end
    end

    for (gi = 0; gi < BTB_N; gi++) begin : g_btb
      always_ff @(posedge clk) begin
        if (rst) begin
          btb_valid_reg[gi]  <= 1'b0;
          btb_tag_reg[gi]    <= '0;
          btb_target_reg[gi] <= '0;
          btb_type_reg[gi]   <= JT_NONE;
        end else if (btb_write && (u_btb_idx == BTB_IDX'(gi))) begin
          btb_valid_reg[gi]  <= 1'b1;
          btb_tag_reg[gi]    <= upd_pc_i[XLEN-1:BTB_IDX+2];
          btb_target_reg[gi] <= upd_target_i;
          btb_type_reg[gi]   <= jump_type_e'(upd_jump_type_i);
        end
      end
    end
  endgenerate

`ifdef BPU_RAS_EN
  localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_CALL = 2'b01;
  localparam logic [1:0] CLS_RET  = 2'b10;

  logic [XLEN-1:0]      ras_reg       [RAS_DEPTH];
  logic [1:0]           btb_class_reg [BTB_N];
  logic [RAS_PTR_W-1:0] ras_ptr_reg;   // next free slot
  logic [RAS_CNT_W-1:0] ras_cnt_reg;
  logic [RAS_PTR_W-1:0] ras_top_idx;
  logic [RAS_PTR_W-1:0] ras_ptr_inc;
  logic [1:0]           upd_class;
  logic                 f_call;
  logic                 f_ret;
  logic                 ras_push;
  logic                 ras_pop;

  assign ras_top_idx = (ras_ptr_reg == '0) ? RAS_PTR_W'(RAS_DEPTH - 1) : ras_ptr_reg - RAS_PTR_W'(1);
  assign ras_ptr_inc = (ras_ptr_reg == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_reg + RAS_PTR_W'(1);
  assign f_call      = f_is_jump && (btb_class_reg[f_btb_idx] == CLS_CALL);
  assign f_ret       = f_is_jump && (btb_class_reg[f_btb_idx] == CLS_RET);
  assign ras_push    = fetch_go && f_call;
  assign ras_pop     = fetch_go && f_ret && (ras_cnt_reg != '0);
  assign jump_target = (f_ret && (ras_cnt_reg != '0)) ? ras_reg[ras_top_idx]
                                                      : btb_target_reg[f_btb_idx];

  always_comb begin
    upd_class = CLS_NONE;
    if (((upd_jump_type_i == JT_JAL) || (upd_jump_type_i == JT_JALR)) &&
        ((upd_rd_i == 5'd1) || (upd_rd_i == 5'd5))) begin
      upd_class = CLS_CALL;
    end else if ((upd_jump_type_i == JT_JALR) && (upd_rd_i == 5'd0)) begin
      upd_class = CLS_RET;
    end
  end

  // Pushing onto a full stack silently overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr_reg <= '0;
      ras_cnt_reg <= '0;
    end else if (ras_push) begin
      ras_ptr_reg <= ras_ptr_inc;
      if (ras_cnt_reg != RAS_CNT_W'(RAS_DEPTH)) ras_cnt_reg <= ras_cnt_reg + RAS_CNT_W'(1);
    end else if (ras_pop) begin
      ras_ptr_reg <= ras_top_idx;
      ras_cnt_reg <= ras_cnt_reg - RAS_CNT_W'(1);
    end
  end

  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      always_ff @(posedge clk) begin
        if (rst)                                              ras_reg[gi] <= '0;
        else if (ras_push && (ras_ptr_reg == RAS_PTR_W'(gi))) ras_reg[gi] <= fetch_pc_plus4;
      end
    end

    for (gi = 0; gi < BTB_N; gi++) begin : g_btb_class
      always_ff @(posedge clk) begin
        if (rst)                                               btb_class_reg[gi] <= CLS_NONE;
        else if (btb_write && (u_btb_idx == BTB_IDX'(gi)))     btb_class_reg[gi] <= upd_class;
      end
    end
  endgenerate
`else
  assign jump_target = btb_target_reg[f_btb_idx];
`endif

  // Inputs carried for interface completeness but not needed by the tables.
  logic unused_inputs;
  assign unused_inputs = ^{upd_rd_i, upd_which_pdt_i, upd_pc_i[1:0], RAS_DEPTH[0]};

endmodule

// File: tb/tb_bpu_tournament.sv
// Scoreboard bench for bpu_tournament: a table-level reference model predicts every cycle's outputs.
// Define BPU_RAS_EN for both bench and RTL to exercise the return stack.
module tb_bpu_tournament;

  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_stall;
  logic [31:0] fetch_pc;
  logic        pdt_res, which_pdt;
  logic [31:0] pdt_target, pdt_tag;
  logic [7:0]  history;
  logic        upd_valid, upd_taken, upd_correct, upd_which;
  logic [31:0] upd_pc, upd_target;
  logic [7:0]  upd_history;
  logic [1:0]  upd_jt;
  logic [4:0]  upd_rd;

  always #5 clk = ~clk;

  bpu_tournament #(.XLEN(32), .HISLEN(8), .BHT_IDX(8), .BTB_IDX(5), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_i(fetch_valid), .fetch_stall_i(fetch_stall), .fetch_pc_i(fetch_pc),
    .pdt_res_o(pdt_res), .pdt_target_o(pdt_target), .pdt_tag_o(pdt_tag),
    .which_pdt_o(which_pdt), .history_o(history),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_correct_i(upd_correct), .upd_which_pdt_i(upd_which),
    .upd_history_i(upd_history), .upd_jump_type_i(upd_jt), .upd_rd_i(upd_rd)
  );

  typedef struct {
    logic        res;
    logic [31:0] tgt;
    logic [31:0] tag;
    logic        which;
    logic [7:0]  hist;
  } out_t;

  // Reference model state: plain counters and BTB records.
  int          m_bim [256];
  int          m_gsh [256];
  int          m_cho [256];
  bit          m_btb_v   [32];
  bit [24:0]   m_btb_tag [32];
  bit [31:0]   m_btb_tgt [32];
  int          m_btb_jt  [32];
  int          m_btb_cls [32];   // 1 call, 2 return
  bit [7:0]    m_ghr;
  bit [31:0]   m_ras [$];
  out_t        m_out;
  out_t        exp_q [$];

  int total  = 0;
  int passed = 0;
  int n_txn  = 0;

  function automatic int sat(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_bim[i] = 1; m_gsh[i] = 1; m_cho[i] = 1;
    end
    for (int i = 0; i < 32; i++) begin
      m_btb_v[i] = 0; m_btb_tag[i] = 0; m_btb_tgt[i] = 0; m_btb_jt[i] = 0; m_btb_cls[i] = 0;
    end
    m_ghr = 0;
    m_ras.delete();
  endtask

  // Computes what the outputs must show after the coming clock edge, then advances the model.
  task automatic model_step();
    out_t     n;
    bit [7:0] g_next;
    int       bi, gi, ti, ub, ug, ut, ctr;
    bit       hit, bp, gp;
    n = m_out;
    g_next = m_ghr;
    if (rst) begin
      model_reset();
      n = '{res: 1'b0, tgt: 32'h0, tag: 32'h0, which: 1'b0, hist: 8'h0};
    end else begin
      if (fetch_valid && !fetch_stall) begin
        bi  = int'(fetch_pc[9:2]);
        gi  = int'(fetch_pc[9:2] ^ m_ghr);
        ti  = int'(fetch_pc[6:2]);
        hit = m_btb_v[ti] && (m_btb_tag[ti] == fetch_pc[31:7]);
        n.tag = fetch_pc; n.hist = m_ghr; n.which = (m_cho[bi] >= 2);
        n.res = 1'b0; n.tgt = fetch_pc + 32'd4;
        if (hit && m_btb_jt[ti] == 3) begin
          ctr   = (m_cho[bi] >= 2) ? m_gsh[gi] : m_bim[bi];
          n.res = (ctr >= 2);
          if (n.res) n.tgt = m_btb_tgt[ti];
          g_next = {m_ghr[6:0], n.res};
        end else if (hit) begin
          n.res = 1'b1; n.tgt = m_btb_tgt[ti];
`ifdef BPU_RAS_EN
          if (m_btb_cls[ti] == 1) begin
            m_ras.push_back(fetch_pc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
          end else if (m_btb_cls[ti] == 2 && m_ras.size() > 0) begin
            n.tgt = m_ras.pop_back();
          end
`endif
        end
      end else if (!fetch_stall) begin
        n.res = 1'b0;
      end
      if (upd_valid && upd_jt != 2'b00) begin
        ub = int'(upd_pc[9:2]);
        ug = int'(upd_pc[9:2] ^ upd_history);
        ut = int'(upd_pc[6:2]);
        if (upd_jt == 2'b11) begin
          bp = (m_bim[ub] >= 2);
          gp = (m_gsh[ug] >= 2);
          if (bp != gp) m_cho[ub] = sat(m_cho[ub], gp == upd_taken);
          m_bim[ub] = sat(m_bim[ub], upd_taken);
          m_gsh[ug] = sat(m_gsh[ug], upd_taken);
        end
        if (upd_taken) begin
          m_btb_v[ut] = 1; m_btb_tag[ut] = upd_pc[31:7]; m_btb_tgt[ut] = upd_target;
          m_btb_jt[ut] = int'(upd_jt);
          if ((upd_jt == 2'b01 || upd_jt == 2'b10) && (upd_rd == 5'd1 || upd_rd == 5'd5))
            m_btb_cls[ut] = 1;
          else if (upd_jt == 2'b10 && upd_rd == 5'd0)
            m_btb_cls[ut] = 2;
          else
            m_btb_cls[ut] = 0;
        end
        if (!upd_correct) g_next = (upd_jt == 2'b11) ? {upd_history[6:0], upd_taken} : upd_history;
      end
      m_ghr = g_next;
    end
    m_out = n;
    exp_q.push_back(n);
  endtask

  // One cycle: model sees the driven inputs, edge happens, inputs return to idle.
  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    rst = 0; fetch_valid = 0; fetch_stall = 0; upd_valid = 0;
  endtask

  task automatic set_fetch(input logic [31:0] pc);
    fetch_valid = 1; fetch_pc = pc;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic correct, input logic [7:0] hist, input logic [1:0] jt,
                         input logic [4:0] rd);
    upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    upd_correct = correct; upd_history = hist; upd_jt = jt; upd_rd = rd; upd_which = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s got=%h expected=%h", name, act, req);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 3) == 0) ? 32'h8000_1000 : 32'h8000_0000;
    return base + ($urandom_range(0, 63) << 2);
  endfunction

  // Monitor: every cycle the DUT presents an output set matching the oldest queued expectation.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        total++;
        if ({pdt_res, pdt_target, pdt_tag, which_pdt, history} ===
            {e.res, e.tgt, e.tag, e.which, e.hist}) begin
          passed++;
          $display("txn %0d pred res=%0b tgt=%h tag=%h which=%0b hist=%h ok",
                   n_txn, pdt_res, pdt_target, pdt_tag, which_pdt, history);
        end else begin
          $display("FAIL pred txn %0d got res=%0b tgt=%h tag=%h which=%0b hist=%h expected res=%0b tgt=%h tag=%h which=%0b hist=%h",
                   n_txn, pdt_res, pdt_target, pdt_tag, which_pdt, history,
                   e.res, e.tgt, e.tag, e.which, e.hist);
        end
      end
    end
  end

  initial begin
    logic [31:0] ras_exp [5];
    rst = 1; fetch_valid = 0; fetch_stall = 0; fetch_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_correct = 1;
    upd_which = 0; upd_history = 0; upd_jt = 0; upd_rd = 0;
    m_out = '{res: 1'b0, tgt: 32'h0, tag: 32'h0, which: 1'b0, hist: 8'h0};
    model_reset();

    rst = 1; tick();
    chk("reset_res", {31'd0, pdt_res}, 32'd0);
    chk("reset_tgt", pdt_target, 32'd0);
    rst = 1; tick();

    set_fetch(32'h8000_0000); tick();
    chk("miss_res", {31'd0, pdt_res}, 32'd0);
    chk("miss_tgt", pdt_target, 32'h8000_0004);
    chk("miss_tag", pdt_tag, 32'h8000_0000);
    chk("miss_hist", {24'd0, history}, 32'd0);

    set_upd(32'h8000_0010, 1, 32'h8000_0040, 0, 8'h00, 2'b11, 5'd0); tick();
    set_fetch(32'h8000_0010); tick();
    chk("br_taken_res", {31'd0, pdt_res}, 32'd1);
    chk("br_taken_tgt", pdt_target, 32'h8000_0040);
    chk("ghr_restore_01", {24'd0, history}, 32'h01);

    repeat (5) begin
      set_upd(32'h8000_0010, 0, 32'h0, 1, 8'h00, 2'b11, 5'd0); tick();
    end
    set_fetch(32'h8000_0010); tick();
    chk("sat_low_res", {31'd0, pdt_res}, 32'd0);
    chk("sat_low_tgt", pdt_target, 32'h8000_0014);

    set_upd(32'h8000_0100, 1, 32'h8000_0200, 1, 8'h00, 2'b01, 5'd0); tick();
    set_fetch(32'h8000_0100); tick();
    chk("jal_res", {31'd0, pdt_res}, 32'd1);
    chk("jal_tgt", pdt_target, 32'h8000_0200);

    fetch_stall = 1; set_fetch(32'h8000_0000); tick();
    chk("stall_res", {31'd0, pdt_res}, 32'd1);
    chk("stall_tag", pdt_tag, 32'h8000_0100);
    tick();
    chk("idle_res", {31'd0, pdt_res}, 32'd0);
    chk("idle_tgt", pdt_target, 32'h8000_0200);

    set_fetch(32'h8000_0010);
    set_upd(32'h8000_0030, 1, 32'h8000_0080, 0, 8'h5A, 2'b11, 5'd0); tick();
    set_fetch(32'h8000_0000); tick();
    chk("restore_wins", {24'd0, history}, 32'hB5);

    set_upd(32'h8000_0200, 1, 32'h8000_0400, 0, 8'h33, 2'b11, 5'd0); rst = 1; tick();
    chk("midrst_tag", pdt_tag, 32'h0);
    chk("midrst_hist", {24'd0, history}, 32'h0);
    set_fetch(32'h8000_0100); tick();
    chk("midrst_btb_clear", pdt_target, 32'h8000_0104);

`ifdef BPU_RAS_EN
    set_upd(32'h8000_0020, 1, 32'h8000_0300, 1, 8'h00, 2'b01, 5'd1); tick();
    set_upd(32'h8000_0300, 1, 32'h8000_0900, 1, 8'h00, 2'b10, 5'd0); tick();
    set_fetch(32'h8000_0020); tick();
    chk("call_tgt", pdt_target, 32'h8000_0300);
    set_fetch(32'h8000_0300); tick();
    chk("ret_tgt", pdt_target, 32'h8000_0024);
    for (int k = 1; k < 5; k++) begin
      set_upd(32'h8000_0020 + 32'(k * 4), 1, 32'h8000_0300, 1, 8'h00, 2'b01, 5'd1); tick();
    end
    for (int k = 0; k < 5; k++) begin
      set_fetch(32'h8000_0020 + 32'(k * 4)); tick();
    end
    ras_exp[0] = 32'h8000_0034; ras_exp[1] = 32'h8000_0030; ras_exp[2] = 32'h8000_002C;
    ras_exp[3] = 32'h8000_0028; ras_exp[4] = 32'h8000_0900;
    for (int k = 0; k < 5; k++) begin
      set_fetch(32'h8000_0300); tick();
      chk($sformatf("ras_pop%0d", k), pdt_target, ras_exp[k]);
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_stall = ($urandom_range(0, 7) == 0);
      fetch_pc    = rand_pc();
      upd_valid   = $urandom_range(0, 1);
      upd_pc      = rand_pc();
      upd_jt      = 2'($urandom_range(0, 3));
      upd_taken   = (upd_jt == 2'b01 || upd_jt == 2'b10) ? 1'b1 : 1'($urandom_range(0, 1));
      upd_target  = rand_pc();
      upd_correct = ($urandom_range(0, 3) != 0);
      upd_history = 8'($urandom);
      upd_which   = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       upd_rd = 5'd0;
        1:       upd_rd = 5'd1;
        2:       upd_rd = 5'd5;
        default: upd_rd = 5'd2;
      endcase
      if (c == 1500) rst = 1;
      tick();
    end

    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
